branch_hazard_ctrl: RTL and testbench

BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

---
 rtl/branch_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_ctrl.sv
// Branch hazard controller for a pipeline that resolves branches in ID.
// Detects RAW hazards on the branch comparator sources, stalls the front end
// for the required number of cycles, selects comparator forwarding paths, and
// keeps saturating branch statistics.
module branch_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_branch,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        mem_regwrite,
  input  logic        mem_memread,
  input  logic [4:0]  mem_rd,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic        branch_ok,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        pc_src,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        br_busy,
  output logic [15:0] br_total,
  output logic [15:0] br_taken,
  output logic [15:0] br_stalls
);

  typedef enum logic {StIdle, StWait} state_t;

  state_t     state_q;
  logic [1:0] cnt_q;
  // Branch captured when stalling, so ID changes during WAIT are ignored.
  logic [2:0] code_q;
  logic [4:0] rs_q;
  logic [4:0] rt_q;

  logic [2:0] code;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       valid;
  logic       use_rs;
  logic       use_rt;
  logic [1:0] need_a;
  logic [1:0] need_b;
  logic [1:0] need;
  logic       eval;
  logic       hold;
  logic       new_stall;
  logic       stall;
  logic       resolve;

  // Stall cycles needed for one source: EX load 2, EX ALU 1, MEM load 1.
  function automatic logic [1:0] src_need(input logic [4:0] src, input logic src_used);
    logic [1:0] n;
    n = 2'd0;
    if (src_used) begin
      if (mem_memread && (mem_rd == src)) n = 2'd1;
      if (ex_regwrite && (ex_rd == src)) n = ex_memread ? 2'd2 : 2'd1;
    end
    return n;
  endfunction

  // Comparator operand source; EX/MEM ALU result beats MEM/WB.
  function automatic logic [1:0] src_fwd(input logic [4:0] src, input logic src_used);
    logic [1:0] f;
    f = 2'b00;
    if (src_used) begin
      if (mem_regwrite && !mem_memread && (mem_rd == src)) f = 2'b01;
      else if (wb_regwrite && (wb_rd == src))               f = 2'b10;
    end
    return f;
  endfunction

  // Hazard evaluation and combinational pipeline control.
  always_comb begin
    code   = (state_q == StWait) ? code_q : id_branch;
    rs     = (state_q == StWait) ? rs_q   : id_rs;
    rt     = (state_q == StWait) ? rt_q   : id_rt;
    valid  = (code != 3'b000) && (code != 3'b111);
    use_rs = valid && (rs != 5'd0);
    use_rt = valid && ((code == 3'b001) || (code == 3'b010)) && (rt != 5'd0);
    need_a = src_need(rs, use_rs);
    need_b = src_need(rt, use_rt);
    need   = (need_a > need_b) ? need_a : need_b;
    // The last WAIT cycle re-evaluates the captured branch like IDLE does.
    eval      = (state_q == StIdle) || (cnt_q == 2'd1);
    hold      = (state_q == StWait) && (cnt_q > 2'd1);
    new_stall = eval && valid && (need != 2'd0);
    stall     = !rst && (hold || new_stall);
    resolve   = !rst && eval && valid && (need == 2'd0) && !hold;

    pc_write    = !stall;
    ifid_write  = !stall;
    idex_bubble = stall;
    pc_src      = resolve && branch_ok;
    ifid_flush  = resolve && branch_ok;
    fwd_a       = rst ? 2'b00 : src_fwd(rs, use_rs);
    fwd_b       = rst ? 2'b00 : src_fwd(rt, use_rt);
    br_busy     = (state_q == StWait);
  end

  // Stall FSM: IDLE/WAIT with a down-counter of remaining stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      code_q  <= 3'b000;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
    end else if (hold) begin
      cnt_q <= cnt_q - 2'd1;
    end else if (new_stall) begin
      state_q <= StWait;
      cnt_q   <= need;
      code_q  <= code;
      rs_q    <= rs;
      rt_q    <= rt;
    end else begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
    end
  end

  // Saturating branch statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_total  <= 16'd0;
      br_taken  <= 16'd0;
      br_stalls <= 16'd0;
    end else begin
      if (resolve && (br_total != 16'hFFFF))              br_total  <= br_total + 16'd1;
      if (resolve && branch_ok && (br_taken != 16'hFFFF)) br_taken  <= br_taken + 16'd1;
      if (stall && (br_stalls != 16'hFFFF))               br_stalls <= br_stalls + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed testbench for branch_hazard_ctrl with hand-computed expectations.
module tb_branch_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  id_branch;
  logic [4:0]  id_rs, id_rt;
  logic        ex_regwrite, ex_memread;
  logic [4:0]  ex_rd;
  logic        mem_regwrite, mem_memread;
  logic [4:0]  mem_rd;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic        branch_ok;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush, pc_src;
  logic [1:0]  fwd_a, fwd_b;
  logic        br_busy;
  logic [15:0] br_total, br_taken, br_stalls;

  int checks = 0;
  int errors = 0;

  // {pc_write, ifid_write, idex_bubble, ifid_flush, pc_src}
  logic [4:0] ctl;
  assign ctl = {pc_write, ifid_write, idex_bubble, ifid_flush, pc_src};
  localparam logic [4:0] Run   = 5'b11000;
  localparam logic [4:0] Stall = 5'b00100;
  localparam logic [4:0] Taken = 5'b11011;

  branch_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_branch    (id_branch),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .mem_rd       (mem_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .branch_ok    (branch_ok),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .pc_src       (pc_src),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .br_busy      (br_busy),
    .br_total     (br_total),
    .br_taken     (br_taken),
    .br_stalls    (br_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_branch = 3'b000; id_rs = 5'd0; id_rt = 5'd0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
    mem_regwrite = 1'b0; mem_memread = 1'b0; mem_rd = 5'd0;
    wb_regwrite = 1'b0; wb_rd = 5'd0; branch_ok = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_ctl(input string name, input logic [4:0] exp);
    checks++;
    if (ctl !== exp) begin
      $display("FAIL %s: ctl got %b expected %b", name, ctl, exp);
      errors++;
    end
  endtask

  task automatic chk_cnt(input string name, input logic [15:0] t, input logic [15:0] k,
                         input logic [15:0] s);
    checks++;
    if ({br_total, br_taken, br_stalls} !== {t, k, s}) begin
      $display("FAIL %s: counters got %0h/%0h/%0h expected %0h/%0h/%0h",
               name, br_total, br_taken, br_stalls, t, k, s);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    chk_ctl("reset_ctl", Run);
    chk_cnt("reset_cnt", 16'd0, 16'd0, 16'd0);
    checks++;
    if ({br_busy, fwd_a, fwd_b} !== 5'b0) begin
      $display("FAIL reset_busy_fwd: got %b expected 00000", {br_busy, fwd_a, fwd_b});
      errors++;
    end
    // A hazardous branch under reset must not stall or forward.
    id_branch = 3'b001; id_rs = 5'd3; ex_regwrite = 1'b1; ex_rd = 5'd3; branch_ok = 1'b1;
    mem_regwrite = 1'b1; mem_rd = 5'd3;
    #1;
    chk_ctl("reset_hazard_ctl", Run);
    checks++;
    if (fwd_a !== 2'b00) begin
      $display("FAIL reset_fwd: got %b expected 00", fwd_a);
      errors++;
    end
    tick();
    checks++;
    if (br_busy !== 1'b0) begin
      $display("FAIL reset_hold_busy: got %b expected 0", br_busy);
      errors++;
    end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_beq_no_hazard();
    id_branch = 3'b001; id_rs = 5'd3; id_rt = 5'd4; branch_ok = 1'b1;
    #1;
    chk_ctl("beq_resolve", Taken);
    tick();
    chk_cnt("beq_cnt", 16'd1, 16'd1, 16'd0);
    clear_inputs();
  endtask

  task automatic test_bne_load();
    id_branch = 3'b010; id_rs = 5'd5; id_rt = 5'd9;
    ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; branch_ok = 1'b1;
    #1;
    chk_ctl("bne_stall0", Stall);
    tick();
    // Load moves to MEM; ID changes are ignored while waiting.
    clear_inputs();
    mem_regwrite = 1'b1; mem_memread = 1'b1; mem_rd = 5'd5; branch_ok = 1'b1;
    #1;
    chk_ctl("bne_stall1", Stall);
    checks++;
    if (br_busy !== 1'b1) begin
      $display("FAIL bne_busy: got %b expected 1", br_busy);
      errors++;
    end
    tick();
    clear_inputs();
    wb_regwrite = 1'b1; wb_rd = 5'd5; branch_ok = 1'b1;
    #1;
    chk_ctl("bne_resolve", Taken);
    checks++;
    if (fwd_a !== 2'b10) begin
      $display("FAIL bne_fwd_a: got %b expected 10", fwd_a);
      errors++;
    end
    tick();
    chk_cnt("bne_cnt", 16'd2, 16'd2, 16'd2);
    checks++;
    if (br_busy !== 1'b0) begin
      $display("FAIL bne_idle: got %b expected 0", br_busy);
      errors++;
    end
    clear_inputs();
  endtask

  task automatic test_bgez_alu();
    id_branch = 3'b011; id_rs = 5'd7; ex_regwrite = 1'b1; ex_rd = 5'd7;
    #1;
    chk_ctl("bgez_stall", Stall);
    tick();
    clear_inputs();
    mem_regwrite = 1'b1; mem_rd = 5'd7;
    #1;
    chk_ctl("bgez_resolve", Run);
    checks++;
    if (fwd_a !== 2'b01) begin
      $display("FAIL bgez_fwd_a: got %b expected 01", fwd_a);
      errors++;
    end
    tick();
    chk_cnt("bgez_cnt", 16'd3, 16'd2, 16'd3);
    // rt is not a source of BGEZ.
    clear_inputs();
    id_branch = 3'b011; id_rs = 5'd1; id_rt = 5'd7;
    ex_regwrite = 1'b1; ex_rd = 5'd7; branch_ok = 1'b1;
    #1;
    chk_ctl("bgez_rt_ignored", Taken);
    tick();
    chk_cnt("bgez_rt_cnt", 16'd4, 16'd3, 16'd3);
    clear_inputs();
  endtask

  task automatic test_zero_and_priority();
    id_branch = 3'b001; id_rs = 5'd0; id_rt = 5'd2;
    ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd0;
    #1;
    chk_ctl("zero_no_stall", Run);
    checks++;
    if (fwd_a !== 2'b00) begin
      $display("FAIL zero_fwd_a: got %b expected 00", fwd_a);
      errors++;
    end
    tick();
    clear_inputs();
    id_branch = 3'b001; id_rs = 5'd6; id_rt = 5'd0;
    mem_regwrite = 1'b1; mem_rd = 5'd6; wb_regwrite = 1'b1; wb_rd = 5'd6;
    #1;
    chk_ctl("prio_no_stall", Run);
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0100) begin
      $display("FAIL prio_fwd: got %b expected 0100", {fwd_a, fwd_b});
      errors++;
    end
    tick();
    chk_cnt("zero_prio_cnt", 16'd6, 16'd3, 16'd3);
    clear_inputs();
  endtask

  task automatic test_mem_load();
    id_branch = 3'b110; id_rs = 5'd8;
    mem_regwrite = 1'b1; mem_memread = 1'b1; mem_rd = 5'd8;
    #1;
    chk_ctl("memld_stall", Stall);
    checks++;
    if (fwd_a !== 2'b00) begin
      $display("FAIL memld_fwd_stall: got %b expected 00", fwd_a);
      errors++;
    end
    tick();
    clear_inputs();
    wb_regwrite = 1'b1; wb_rd = 5'd8; branch_ok = 1'b1;
    #1;
    chk_ctl("memld_resolve", Taken);
    checks++;
    if (fwd_a !== 2'b10) begin
      $display("FAIL memld_fwd: got %b expected 10", fwd_a);
      errors++;
    end
    tick();
    chk_cnt("memld_cnt", 16'd7, 16'd4, 16'd4);
    clear_inputs();
  endtask

  task automatic test_no_branch();
    logic [2:0] codes [2];
    codes[0] = 3'b000;
    codes[1] = 3'b111;
    for (int i = 0; i < 2; i++) begin
      clear_inputs();
      id_branch = codes[i]; id_rs = 5'd4; ex_regwrite = 1'b1; ex_memread = 1'b1;
      ex_rd = 5'd4; branch_ok = 1'b1;
      #1;
      chk_ctl($sformatf("nobranch_%0d", i), Run);
      tick();
    end
    chk_cnt("nobranch_cnt", 16'd7, 16'd4, 16'd4);
    clear_inputs();
  endtask

  task automatic test_residual();
    id_branch = 3'b001; id_rs = 5'd10; id_rt = 5'd11;
    ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd10;
    #1;
    chk_ctl("resid_stall0", Stall);
    tick();
    clear_inputs();
    #1;
    chk_ctl("resid_stall1", Stall);
    tick();
    ex_regwrite = 1'b1; ex_rd = 5'd10;
    #1;
    chk_ctl("resid_restall", Stall);
    tick();
    checks++;
    if (br_busy !== 1'b1) begin
      $display("FAIL resid_busy: got %b expected 1", br_busy);
      errors++;
    end
    clear_inputs();
    mem_regwrite = 1'b1; mem_rd = 5'd10;
    #1;
    chk_ctl("resid_resolve", Run);
    checks++;
    if (fwd_a !== 2'b01) begin
      $display("FAIL resid_fwd: got %b expected 01", fwd_a);
      errors++;
    end
    tick();
    chk_cnt("resid_cnt", 16'd8, 16'd4, 16'd7);
    clear_inputs();
  endtask

  task automatic test_reset_in_wait();
    id_branch = 3'b010; id_rs = 5'd5; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5;
    tick();
    tick();
    clear_inputs();
    branch_ok = 1'b1;
    #1;
    chk_ctl("rstw_pending", Taken);
    chk_cnt("rstw_before", 16'd8, 16'd4, 16'd9);
    rst = 1'b1;
    #1;
    chk_ctl("rstw_async_ctl", Run);
    chk_cnt("rstw_async_cnt", 16'd0, 16'd0, 16'd0);
    checks++;
    if (br_busy !== 1'b0) begin
      $display("FAIL rstw_busy: got %b expected 0", br_busy);
      errors++;
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();
    chk_cnt("rstw_abandoned", 16'd0, 16'd0, 16'd0);
  endtask

  task automatic test_saturation();
    id_branch = 3'b001; id_rs = 5'd3; id_rt = 5'd4; branch_ok = 1'b1;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    chk_cnt("sat_reach", 16'hFFFF, 16'hFFFF, 16'd0);
    tick();
    chk_cnt("sat_hold", 16'hFFFF, 16'hFFFF, 16'd0);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_beq_no_hazard();
    test_bne_load();
    test_bgez_alu();
    test_zero_and_priority();
    test_mem_load();
    test_no_branch();
    test_residual();
    test_reset_in_wait();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
